fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/instruction width.
REQ-002 SHALL have parameter QDEPTH, default 4, meaning fetch-queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_VEC, default 32'h0, meaning PC on status Reset.
REQ-004 SHALL have parameter IRQ_VEC, default 32'h4, meaning PC on status Interrupt.
REQ-005 SHALL have parameter EXC_VEC, default 32'h8, meaning PC on status Exception.
REQ-006 SHALL have ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: imem_addr  out  XLEN  current PC; imem_rdata  in  XLEN  instruction at imem_addr, same cycle (combinational ROM).
REQ-008 SHALL have ports: redirect  in  3  one-hot {branch, jump, jr}; branch_target, jump_target, jr_target  in  XLEN each.
REQ-009 SHALL have ports: status  in  2  00 normal, 01 Reset, 10 Interrupt, 11 Exception.
REQ-010 SHALL have ports: id_valid  out  1; id_ready  in  1; id_pc_plus4  out  XLEN; id_instr  out  XLEN (queue head).
REQ-011 SHALL have ports: q_count  out  clog2(QDEPTH)+1  occupancy; redirect_err  out  1  sticky illegal-redirect flag.

Function
REQ-012 pc_plus4 SHALL be {PC[XLEN-1], PC[XLEN-2:0]+4}; top (kernel) bit preserved, low field wraps.
REQ-013 Push SHALL occur when no redirect, status==00, and (q_count<QDEPTH or pop this cycle); entry = {pc_plus4, imem_rdata}; PC <= pc_plus4.
REQ-014 Pop SHALL occur when id_valid && id_ready; id_valid = (q_count!=0); head outputs valid same cycle as id_valid.
REQ-015 Full with no pop: no push, PC holds (fetch stall); simultaneous push+pop at full SHALL keep q_count==QDEPTH.
REQ-016 Empty: id_valid=0; push to empty queue SHALL appear at head next cycle (1-cycle latency).
REQ-017 Legal one-hot redirect SHALL: PC <= selected target, flush all queue entries (q_count<=0), no push, ignore id_ready that cycle.
REQ-018 Redirect SHALL take priority over status; status SHALL be acted on only when redirect==000.
REQ-019 redirect==000, status!=00: PC <= corresponding vector, queue flushed, no push.
REQ-020 Non-one-hot nonzero redirect SHALL: PC <= all-ones, flush queue, set redirect_err until reset.
REQ-021 Redirect/flush SHALL act regardless of queue fullness.
REQ-022 Pointers SHALL wrap modulo QDEPTH; queue SHALL be circular with separate read/write pointers and count.

Reset
REQ-023 On rst_n low, asynchronously: PC=RESET_VEC, q_count=0, pointers=0, id_valid=0, redirect_err=0; queue storage need not clear.
REQ-024 Reset asserted mid-operation SHALL discard all queued entries; first fetch after release from RESET_VEC.

Structure
REQ-025 Status encodings, redirect one-hot encodings and default vectors SHALL live in shared package cpu_pkg.
REQ-026 Queue SHALL be a sub-module sync_fifo (parameters WIDTH=2*XLEN, DEPTH=QDEPTH, with synchronous flush).
REQ-027 Instruction memory SHALL remain external to this block.

Verification
REQ-028 Reset release, id_ready=1, status=00: imem_addr 0,4,8,...; id_pc_plus4 4,8,12 one cycle after each fetch.
REQ-029 id_ready=0 for 6 cycles, QDEPTH=4: q_count saturates at 4, PC stalls at 16; id_ready=1 drains in order with pc_plus4 4,8,12,16.
REQ-030 Queue holding 3 entries, redirect=100, branch_target=0x40: next cycle q_count=0, id_valid=0, imem_addr=0x40.
REQ-031 redirect=000, status=10: PC=0x4, queue flushed; same cycle redirect=010 jump_target=0x80: PC=0x80 (redirect wins).
REQ-032 PC=0x8000_0FFC, normal fetch: id_pc_plus4=0x8000_1000; PC=0xFFFF_FFFC: next PC=0x8000_0000.
REQ-033 redirect=110: PC=0xFFFF_FFFF, redirect_err=1 persisting until rst_n low; mid-drain reset clears q_count to 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: fetch status codes, redirect one-hot
// select bits and default trap vectors.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'b00,
    ST_RESET  = 2'b01,
    ST_IRQ    = 2'b10,
    ST_EXC    = 2'b11
  } status_e;

  localparam logic [2:0] REDIR_BRANCH = 3'b100;
  localparam logic [2:0] REDIR_JUMP   = 3'b010;
  localparam logic [2:0] REDIR_JR     = 3'b001;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_IRQ_VEC   = 32'h0000_0004;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0008;

  function automatic logic is_onehot3(logic [2:0] v);
    return (v != 3'b000) && ((v & (v - 3'd1)) == 3'b000);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready bundle carrying the queue head.
// The fetch side is the master.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc_plus4;
  logic [XLEN-1:0] id_instr;

  modport master (
    output id_valid,
    output id_pc_plus4,
    output id_instr,
    input  id_ready
  );

  modport slave (
    input  id_valid,
    input  id_pc_plus4,
    input  id_instr,
    output id_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Circular FIFO with separate read/write pointers, an occupancy
// count and a synchronous flush. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  // A write into a full queue is only legal when a slot frees this cycle.
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, redirect/trap steering and a
// small fetch queue feeding decode over a valid/ready handshake.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              QDEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] IRQ_VEC   = XLEN'(DEF_IRQ_VEC),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEF_EXC_VEC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [XLEN-1:0]         imem_addr,
  input  logic [XLEN-1:0]         imem_rdata,
  input  logic [2:0]              redirect,
  input  logic [XLEN-1:0]         branch_target,
  input  logic [XLEN-1:0]         jump_target,
  input  logic [XLEN-1:0]         jr_target,
  input  logic [1:0]              status,
  fetch_unit_if.master            id,
  output logic [$clog2(QDEPTH):0] q_count,
  output logic                    redirect_err
);
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_nxt;
  logic [XLEN-1:0]   pc_plus4;
  logic [2*XLEN-1:0] head;
  logic              redir_any;
  logic              redir_bad;
  logic              trap;
  logic              flush;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  // Kernel bit is sticky; only the low field advances and wraps.
  assign pc_plus4  = {pc[XLEN-1], pc[XLEN-2:0] + (XLEN-1)'(4)};
  assign redir_any = (redirect != 3'b000);
  assign redir_bad = redir_any && !is_onehot3(redirect);
  assign trap      = !redir_any && (status != ST_NORMAL);
  assign flush     = redir_any || trap;
  assign pop       = id.id_valid && id.id_ready && !flush;
  assign push      = !flush && (!full || pop);

  always_comb begin
    pc_nxt = pc;
    unique case (1'b1)
      redirect == REDIR_BRANCH:       pc_nxt = branch_target;
      redirect == REDIR_JUMP:         pc_nxt = jump_target;
      redirect == REDIR_JR:           pc_nxt = jr_target;
      redir_bad:                      pc_nxt = '1;
      trap && (status == ST_RESET):   pc_nxt = RESET_VEC;
      trap && (status == ST_IRQ):     pc_nxt = IRQ_VEC;
      trap && (status == ST_EXC):     pc_nxt = EXC_VEC;
      push:                           pc_nxt = pc_plus4;
      default:                        pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_VEC;
      redirect_err <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (redir_bad) redirect_err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({pc_plus4, imem_rdata}),
    .rdata (head),
    .count (q_count),
    .full  (full),
    .empty (empty)
  );

  assign imem_addr      = pc;
  assign id.id_valid    = !empty;
  assign id.id_pc_plus4 = head[2*XLEN-1:XLEN];
  assign id.id_instr    = head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a reference PC/queue model
// acting as scoreboard.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [2:0]  redirect = 3'b000;
  logic [31:0] branch_target = '0;
  logic [31:0] jump_target = '0;
  logic [31:0] jr_target = '0;
  logic [1:0]  status = 2'b00;
  logic [2:0]  q_count;
  logic        redirect_err;

  fetch_unit_if #(.XLEN(32)) id_if ();

  fetch_unit #(
    .XLEN(32),
    .QDEPTH(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .status        (status),
    .id            (id_if.master),
    .q_count       (q_count),
    .redirect_err  (redirect_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata = rom(imem_addr);

  int total = 0;
  int bad = 0;
  logic [63:0] sb[$];
  logic [31:0] m_pc = 32'h0;
  logic        m_err = 1'b0;

  function automatic logic [31:0] p4(logic [31:0] p);
    return {p[31], p[30:0] + 31'd4};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc = 32'h0;
    m_err = 1'b0;
  endtask

  // Compare live outputs against the model, advance the model
  // across the coming edge, then wait for the next negedge.
  task automatic step();
    logic do_pop;
    logic is_full;
    #1;
    chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    chk("id_valid", 64'(id_if.id_valid), 64'(sb.size() != 0));
    chk("q_count", 64'(q_count), 64'(sb.size()));
    chk("redirect_err", 64'(redirect_err), 64'(m_err));
    if (sb.size() != 0)
      chk("head", {id_if.id_pc_plus4, id_if.id_instr}, sb[0]);
    if (redirect != 3'b000) begin
      sb.delete();
      case (redirect)
        3'b100:  m_pc = branch_target;
        3'b010:  m_pc = jump_target;
        3'b001:  m_pc = jr_target;
        default: begin
          m_pc = 32'hFFFF_FFFF;
          m_err = 1'b1;
        end
      endcase
    end else if (status != 2'b00) begin
      sb.delete();
      case (status)
        2'b01:   m_pc = 32'h0;
        2'b10:   m_pc = 32'h4;
        default: m_pc = 32'h8;
      endcase
    end else begin
      is_full = (sb.size() == 4);
      do_pop = (sb.size() != 0) && id_if.id_ready;
      if (do_pop) void'(sb.pop_front());
      if (!is_full || do_pop) begin
        sb.push_back({p4(m_pc), rom(m_pc)});
        m_pc = p4(m_pc);
      end
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst q_count", 64'(q_count), 64'd0);
    chk("rst id_valid", 64'(id_if.id_valid), 64'd0);
    chk("rst err", 64'(redirect_err), 64'd0);
    chk("rst imem_addr", 64'(imem_addr), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    id_if.id_ready = 1'b1;
    pulse_reset();

    // Streaming fetch with decode always ready.
    repeat (3) step();
    #1;
    chk("stream pc_plus4", 64'(id_if.id_pc_plus4), 64'd12);
    chk("stream addr", 64'(imem_addr), 64'd12);
    repeat (3) step();

    // Back-pressure: fill to QDEPTH, stall, then drain in order.
    pulse_reset();
    id_if.id_ready = 1'b0;
    repeat (6) step();
    #1;
    chk("full count", 64'(q_count), 64'd4);
    chk("stall addr", 64'(imem_addr), 64'd16);
    chk("full head", 64'(id_if.id_pc_plus4), 64'd4);
    id_if.id_ready = 1'b1;
    repeat (5) step();

    // Branch redirect flushes a partly filled queue.
    pulse_reset();
    id_if.id_ready = 1'b0;
    repeat (3) step();
    redirect = 3'b100;
    branch_target = 32'h40;
    id_if.id_ready = 1'b1;
    step();
    redirect = 3'b000;
    id_if.id_ready = 1'b0;
    #1;
    chk("br q_count", 64'(q_count), 64'd0);
    chk("br id_valid", 64'(id_if.id_valid), 64'd0);
    chk("br addr", 64'(imem_addr), 64'h40);
    repeat (2) step();

    // Interrupt vector, then redirect beating a pending status.
    status = 2'b10;
    step();
    #1;
    chk("irq addr", 64'(imem_addr), 64'h4);
    redirect = 3'b010;
    jump_target = 32'h80;
    step();
    redirect = 3'b000;
    status = 2'b00;
    #1;
    chk("jump wins", 64'(imem_addr), 64'h80);
    step();
    status = 2'b11;
    step();
    status = 2'b01;
    step();
    status = 2'b00;
    step();

    // Kernel-bit preservation across pc_plus4.
    redirect = 3'b001;
    jr_target = 32'h8000_0FFC;
    step();
    redirect = 3'b000;
    step();
    #1;
    chk("kernel p4", 64'(id_if.id_pc_plus4), 64'h8000_1000);
    redirect = 3'b001;
    jr_target = 32'hFFFF_FFFC;
    step();
    redirect = 3'b000;
    step();
    #1;
    chk("wrap addr", 64'(imem_addr), 64'h8000_0000);

    // Illegal redirect, sticky error, then reset mid-drain.
    redirect = 3'b110;
    step();
    redirect = 3'b000;
    #1;
    chk("bad addr", 64'(imem_addr), 64'hFFFF_FFFF);
    chk("bad err", 64'(redirect_err), 64'd1);
    repeat (3) step();
    #1;
    chk("err sticky", 64'(redirect_err), 64'd1);
    chk("fill count", 64'(q_count), 64'd3);
    id_if.id_ready = 1'b1;
    step();
    #2;
    pulse_reset();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
